multicycle_control: RTL
=======================

# multicycle_control

- Multi-cycle control FSM for the RV32I datapath: sequences fetch, decode, execute, memory and writeback.
- Drives the 3-bit ALU operation code consumed by `alu`.
- Consumes the ALU `Zero` and `Sign_Flag` flags to resolve branches.
- Sits between the instruction register, the shared instruction/data memory handshake, and the datapath muxes and register enables.

## Interface
Parameters: none.

- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- Zero  in  1  ALU result == 0
- Sign_Flag  in  1  ALU result[31]
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- IRWrite  out  1  instruction register and OldPC enable
- RegWrite  out  1  register file write enable
- MemWrite  out  1  data memory write request
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- ALUSrcA  out  2  SrcA select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  SrcB select: 00 = rs2, 01 = immediate, 10 = constant 4
- ResultSrc  out  2  Result select: 00 = ALUOut, 01 = load data, 10 = ALUResult
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  3  ALU operation: 000 add, 001 sll, 010 sub, 100 xor, 101 srl, 110 or, 111 and
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_instr  out  1  sticky unsupported-encoding flag (trap build only)

## Operation
Supported instructions:
- lw (0000011), sw (0100011)
- R-type (0110011): add, sub, sll, xor, srl, or, and
- I-ALU (0010011): addi, slli, xori, srli, ori, andi
- branches (1100011): beq, bne, blt, bge
- jal (1101111)

All other encodings are illegal, including funct3 010/011 and funct7_5=1 on anything other than sub.

States and transitions:
- FETCH: AdrSrc=0, SrcA=PC, SrcB=4, add, ResultSrc=10. Holds until mem_ready; then IRWrite=PCWrite=1 and goes to DECODE.
- DECODE: SrcA=OldPC, SrcB=imm, add (branch/jump target into ALUOut). Goes to MEMADR (lw/sw), EXECR, EXECI, BRANCH, JAL, or the illegal path.
- MEMADR: SrcA=rs1, SrcB=imm, add. Goes to MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: AdrSrc=1. Waits for mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held until mem_ready. Goes to FETCH.
- EXECR: SrcA=rs1, SrcB=rs2, ALUControl decoded from funct3/funct7_5. Goes to ALUWB.
- EXECI: SrcA=rs1, SrcB=imm, ALUControl decoded from funct3. addi is never sub. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
- BRANCH: SrcA=rs1, SrcB=rs2, sub, ResultSrc=00. PCWrite is set by the branch condition:
  - beq: Zero
  - bne: !Zero
  - blt: Sign_Flag
  - bge: !Sign_Flag
  - Then goes to FETCH.
- JAL: SrcA=OldPC, SrcB=4, add, ResultSrc=00, PCWrite=1. Goes to ALUWB (writes PC+4 to rd).

Other rules:
- ImmSrc decodes combinationally from opcode in every state.
- instr_done pulses on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.
- blt/bge use Sign_Flag of the subtraction only; overflow is not corrected.

## Timing
- Cycle counts: lw 5, sw 4, R/I 4, branch 3, jal 4. Each memory wait cycle adds one.
- Reset: state=FETCH and illegal_instr=0. PCWrite, IRWrite, RegWrite, MemWrite and instr_done are forced 0 while rst is high; all other outputs take their FETCH values.
- Reset deasserted mid-instruction restarts at FETCH with no partial writes.
- mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- MemWrite stays stable until mem_ready is sampled high.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: an illegal encoding in DECODE enters TRAP. TRAP holds all enables at 0, sets illegal_instr, and exits only on rst.
- Undefined: an illegal encoding goes DECODE→FETCH as a NOP, instr_done pulses, and illegal_instr is tied to 0.

## Structure
- Package `ctrl_pkg` holds:
  - the state enum
  - opcode constants
  - ALUControl codes, shared with `alu`
  - mux select encodings for ALUSrcA, ALUSrcB, ResultSrc and ImmSrc
- Sub-module `alu_decoder` (combinational): maps state class, funct3 and funct7_5 to ALUControl plus an illegal flag.

## Test plan
- Reset: rst high mid-MEMREAD → state FETCH, all enables 0; after release, first FETCH with mem_ready=1 gives IRWrite=PCWrite=1.
- lw, mem_ready always 1 → RegWrite=1 with ResultSrc=01 in cycle 5, instr_done pulse.
- sw, mem_ready low 3 cycles in MEMWRITE → MemWrite held 4 cycles, 7 cycles total.
- R-type sub (funct3=000, funct7_5=1) → ALUControl=010 in EXECR; srli → 101; ori → 110.
- beq with Zero=1 → PCWrite=1 in BRANCH; bge with Sign_Flag=1 → PCWrite=0; blt with Sign_Flag=1 → PCWrite=1.
- opcode 0110111: trap build → TRAP, illegal_instr=1 until rst; non-trap build → back to FETCH after 2 cycles with instr_done pulse.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit: FSM states, opcodes,
// ALU operation codes (also used by alu) and datapath mux selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    // Which flavour of ALU operation the current state needs
    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_SUB,
        CLS_RTYPE,
        CLS_ITYPE
    } alu_class_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_WORD = 3'b010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_LOAD      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder: maps the state's ALU class plus
// funct3/funct7_5 to an ALUControl code and flags unsupported R/I encodings.
module alu_decoder
    import ctrl_pkg::*;
(
    input  alu_class_t  alu_class,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    output logic [2:0]  alu_control,
    output logic        illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (alu_class)
            CLS_SUB: alu_control = ALU_SUB;
            CLS_RTYPE, CLS_ITYPE: begin
                case (funct3)
                    3'b000:  alu_control = (alu_class == CLS_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: illegal = 1'b1;
                endcase
                // instr[30] is only a function bit for R-type ops and immediate shifts
                if (funct7_5) begin
                    if (alu_class == CLS_RTYPE && funct3 != 3'b000)
                        illegal = 1'b1;
                    if (alu_class == CLS_ITYPE && (funct3 == 3'b001 || funct3 == 3'b101))
                        illegal = 1'b1;
                end
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM (fetch/decode/execute/memory/writeback).
// Define CTRL_ILLEGAL_TRAP_EN to lock into a TRAP state on illegal encodings.
module multicycle_control
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       Zero,
    input  logic       Sign_Flag,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       illegal_instr
);

    state_t     state_reg, state_next;
    alu_class_t alu_class;
    logic [2:0] dec_alu_control;
    logic       dec_illegal;
    logic       instr_ok;
    logic       branch_taken;

    // In DECODE the decoder checks legality of the fetched op; later it drives ALUControl
    always_comb begin
        alu_class = CLS_ADD;
        case (state_reg)
            S_DECODE: begin
                if (opcode == OP_RTYPE)
                    alu_class = CLS_RTYPE;
                else if (opcode == OP_IALU)
                    alu_class = CLS_ITYPE;
            end
            S_EXECR:  alu_class = CLS_RTYPE;
            S_EXECI:  alu_class = CLS_ITYPE;
            S_BRANCH: alu_class = CLS_SUB;
            default:  alu_class = CLS_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_class   (alu_class),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .alu_control (dec_alu_control),
        .illegal     (dec_illegal)
    );

    always_comb begin
        case (opcode)
            OP_LOAD, OP_STORE: instr_ok = (funct3 == F3_WORD);
            OP_RTYPE, OP_IALU: instr_ok = !dec_illegal;
            OP_BRANCH:         instr_ok = funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE};
            OP_JAL:            instr_ok = 1'b1;
            default:           instr_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (funct3)
            F3_BEQ:  branch_taken = Zero;
            F3_BNE:  branch_taken = !Zero;
            F3_BLT:  branch_taken = Sign_Flag;
            F3_BGE:  branch_taken = !Sign_Flag;
            default: branch_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= S_FETCH;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH: if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (!instr_ok) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_next = S_TRAP;
`else
                    state_next = S_FETCH;
`endif
                end else begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_next = S_MEMADR;
                        OP_RTYPE:          state_next = S_EXECR;
                        OP_IALU:           state_next = S_EXECI;
                        OP_BRANCH:         state_next = S_BRANCH;
                        OP_JAL:            state_next = S_JAL;
                        default:           state_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        ALUControl = ALU_ADD;
        ImmSrc     = imm_src_of(opcode);
        // Every retirement (including a non-trapping illegal NOP) is a return to FETCH
        instr_done = (state_next == S_FETCH) && (state_reg != S_FETCH);
        case (state_reg)
            S_FETCH: begin
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_LOAD;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUControl = dec_alu_control;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = dec_alu_control;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUControl = dec_alu_control;
                ResultSrc  = RES_ALUOUT;
                PCWrite    = branch_taken;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                PCWrite   = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            instr_done = 1'b0;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            illegal_reg <= 1'b0;
        else if (state_reg == S_DECODE && !instr_ok)
            illegal_reg <= 1'b1;
    end

    assign illegal_instr = illegal_reg;
`else
    assign illegal_instr = 1'b0;
`endif

endmodule
